uart_tx_fifo: RTL and testbench

- Byte FIFO plus load sequencer between dsd_processor's UART port and UART_top.
- Lets the processor write a burst of bytes without polling transmitter-empty per byte.
- Drains one byte at a time into UART_top using UART_top's TE/load handshake.
- The processor-facing side looks like the existing UART interface: cpu_te is high when a write will be accepted.

---
 rtl/uart_tx_fifo.sv | 145 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and load sequencer between the processor's UART port and UART_top.
// Bursts are queued here and handed over one byte per TE/load handshake.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TE_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cpu_wr,
    input  logic [7:0]            cpu_din,
    output logic                  cpu_te,
    input  logic                  uart_te,
    output logic                  uart_load,
    output logic [7:0]            uart_din,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  te_timeout
);

    localparam int                DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [7:0]        TIMER_LAST = 8'(TE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic [7:0]              timer_q, timer_d;
    logic [7:0]              uart_din_q, uart_din_d;
    logic                    uart_load_q, uart_load_d;
    logic                    overflow_q, overflow_d;
    logic                    te_timeout_q, te_timeout_d;
    logic [7:0]              mem_q [DEPTH];

    logic full, empty, push, pop;

    // Full is judged on the registered count, so a pop in the same cycle
    // never makes room for a write that arrives while full.
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign push  = cpu_wr && !full;
    assign pop   = (state_q == IDLE) && !empty && uart_te;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (cpu_wr && full) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        uart_load_d  = 1'b0;
        uart_din_d   = uart_din_q;
        te_timeout_d = te_timeout_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    uart_din_d  = mem_q[rd_ptr_q];
                    uart_load_d = 1'b1;
                    timer_d     = '0;
                    state_d     = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // A transmitter that never drops TE is abandoned after
                // TE_TIMEOUT cycles so the queue keeps draining.
                if (!uart_te) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    te_timeout_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (uart_te) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            uart_din_q   <= 8'h00;
            uart_load_q  <= 1'b0;
            overflow_q   <= 1'b0;
            te_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            uart_din_q   <= uart_din_d;
            uart_load_q  <= uart_load_d;
            overflow_q   <= overflow_d;
            te_timeout_q <= te_timeout_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem_q[wr_ptr_q] <= cpu_din;
        end
    end

    assign cpu_te     = !full;
    assign uart_load  = uart_load_q;
    assign uart_din   = uart_din_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign te_timeout = te_timeout_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural UART_top answers each load, bytes
// written are queued as expected and matched against the bytes loaded.
module tb_uart_tx_fifo;

    localparam int TE_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cpu_wr;
    logic [7:0] cpu_din;
    logic       cpu_te;
    logic       uart_te;
    logic       uart_load;
    logic [7:0] uart_din;
    logic [4:0] count;
    logic       overflow;
    logic       te_timeout;

    uart_tx_fifo #(.DEPTH_LOG2(4), .TE_TIMEOUT(TE_TIMEOUT)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cpu_wr     (cpu_wr),
        .cpu_din    (cpu_din),
        .cpu_te     (cpu_te),
        .uart_te    (uart_te),
        .uart_load  (uart_load),
        .uart_din   (uart_din),
        .count      (count),
        .overflow   (overflow),
        .te_timeout (te_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // UART_top model: 0 = normal (TE falls 2 cycles after load, rises
    // model_busy cycles later), 1 = TE stuck high, 2 = TE held low.
    int model_mode = 0;
    int model_busy = 100;

    initial begin
        uart_te = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (model_mode == 2) begin
                uart_te = 1'b0;
            end else if (model_mode == 1) begin
                uart_te = 1'b1;
            end else if (uart_load === 1'b1) begin
                repeat (2) @(posedge clk);
                #1 uart_te = 1'b0;
                repeat (model_busy) @(posedge clk);
                #1 uart_te = 1'b1;
            end else begin
                uart_te = 1'b1;
            end
        end
    end

    // Monitor: collect loaded bytes and record protocol violations.
    int         cyc = 0;
    int         n_loads = 0;
    int         last_load_cyc = 0;
    int         teto_cyc = 0;
    int         wide_err = 0;
    int         din_err = 0;
    int         bound_err = 0;
    logic       rst_at_edge = 1'b1;
    logic       prev_load = 1'b0;
    logic       prev_teto = 1'b0;
    logic [7:0] prev_din = 8'h00;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= (resetn !== 1'b1);
    end

    always @(negedge clk) begin
        if (uart_load === 1'b1) begin
            got_q.push_back(uart_din);
            n_loads++;
            last_load_cyc = cyc;
            if (prev_load) wide_err++;
        end else if (!rst_at_edge && uart_din !== prev_din) begin
            din_err++;
        end
        if (count > 5'd16) bound_err++;
        if (te_timeout === 1'b1 && !prev_teto) teto_cyc = cyc;
        prev_load = (uart_load === 1'b1);
        prev_teto = (te_timeout === 1'b1);
        prev_din  = uart_din;
    end

    task automatic drive_wr(input logic en, input logic [7:0] b);
        @(posedge clk);
        #1;
        cpu_wr  = en;
        cpu_din = b;
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (cpu_te !== 1'b1) begin n_mis++; $display("FAIL reset_cpu_te: got %b want 1", cpu_te); end
        n_cmp++; if (uart_load !== 1'b0) begin n_mis++; $display("FAIL reset_load: got %b want 0", uart_load); end
        n_cmp++; if (uart_din !== 8'h00) begin n_mis++; $display("FAIL reset_din: got %02h want 00", uart_din); end
        n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (te_timeout !== 1'b0) begin n_mis++; $display("FAIL reset_te_timeout: got %b want 0", te_timeout); end
        wait_cycles(3);
        n_cmp++; if (n_loads !== 0) begin n_mis++; $display("FAIL reset_idle_load: got %0d loads want 0", n_loads); end
    endtask

    task automatic test_single_byte;
        bit ok;
        int loads0 = n_loads;
        model_busy = 100;
        drive_wr(1'b1, 8'h41);
        exp_q.push_back(8'h41);
        drive_wr(1'b0, 8'h00);
        wait_got(1, 20, ok);
        n_cmp++; if (!ok) begin n_mis++; $display("FAIL single_load_seen: got %0d loads want 1", got_q.size()); end
        wait_cycles(150);
        n_cmp++; if (n_loads - loads0 !== 1) begin n_mis++; $display("FAIL single_load_count: got %0d want 1", n_loads - loads0); end
        n_cmp++; if (uart_din !== 8'h41) begin n_mis++; $display("FAIL single_din_hold: got %02h want 41", uart_din); end
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL single_count: got %0d want 0", count); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g = got_q.pop_front();
            logic [7:0] e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_mis++; $display("FAIL single_data: got %02h want %02h", g, e); end
        end
        n_cmp++; if (wide_err !== 0) begin n_mis++; $display("FAIL single_pulse_width: got %0d wide pulses want 0", wide_err); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_burst;
        bit ok;
        model_busy = 20;
        for (int i = 0; i < 16; i++) begin
            drive_wr(1'b1, 8'(i));
            exp_q.push_back(8'(i));
        end
        drive_wr(1'b0, 8'h00);
        // The first byte leaves one cycle after it lands; the next load
        // waits on a full TE cycle, so exactly one has drained by now.
        n_cmp++; if (count !== 5'd15) begin n_mis++; $display("FAIL burst_count: got %0d want 15", count); end
        n_cmp++; if (cpu_te !== 1'b1) begin n_mis++; $display("FAIL burst_cpu_te: got %b want 1", cpu_te); end
        wait_got(16, 1000, ok);
        n_cmp++; if (!ok) begin n_mis++; $display("FAIL burst_drain: got %0d bytes want 16", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g = got_q.pop_front();
            logic [7:0] e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_mis++; $display("FAIL burst_data: got %02h want %02h", g, e); end
        end
        n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL burst_overflow: got %b want 0", overflow); end
        wait_cycles(40);
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL burst_empty: got %0d want 0", count); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_overflow;
        bit ok;
        int fill = 0;
        model_busy = 3;
        model_mode = 2;
        wait_cycles(3);
        for (int i = 0; i < 17; i++) begin
            drive_wr(1'b1, 8'hA0 + 8'(i));
            if (fill < 16) begin
                exp_q.push_back(8'hA0 + 8'(i));
                fill++;
            end
        end
        drive_wr(1'b0, 8'h00);
        n_cmp++; if (count !== 5'd16) begin n_mis++; $display("FAIL ovf_count: got %0d want 16", count); end
        n_cmp++; if (cpu_te !== 1'b0) begin n_mis++; $display("FAIL ovf_cpu_te: got %b want 0", cpu_te); end
        n_cmp++; if (overflow !== 1'b1) begin n_mis++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_cmp++; if (n_loads !== 2 + 16 - 1 + 0 && got_q.size() !== 0) begin n_mis++; $display("FAIL ovf_no_load: got %0d loads want 0", got_q.size()); end
        model_mode = 0;
        wait_got(16, 600, ok);
        n_cmp++; if (!ok) begin n_mis++; $display("FAIL ovf_drain: got %0d bytes want 16", got_q.size()); end
        wait_cycles(60);
        n_cmp++; if (got_q.size() !== 16) begin n_mis++; $display("FAIL ovf_extra_bytes: got %0d bytes want 16", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g = got_q.pop_front();
            logic [7:0] e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_mis++; $display("FAIL ovf_data: got %02h want %02h", g, e); end
        end
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL ovf_empty: got %0d want 0", count); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_wrap;
        bit ok;
        int sent = 0;
        int guard = 0;
        model_busy = 2;
        while (sent < 40 && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
            if (cpu_te === 1'b1 && $urandom_range(0, 3) != 0) begin
                cpu_wr  = 1'b1;
                cpu_din = 8'($urandom);
                exp_q.push_back(cpu_din);
                sent++;
            end else begin
                cpu_wr = 1'b0;
            end
        end
        drive_wr(1'b0, 8'h00);
        n_cmp++; if (sent !== 40) begin n_mis++; $display("FAIL wrap_sent: got %0d want 40", sent); end
        wait_got(40, 1500, ok);
        n_cmp++; if (!ok) begin n_mis++; $display("FAIL wrap_drain: got %0d bytes want 40", got_q.size()); end
        wait_cycles(20);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL wrap_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g = got_q.pop_front();
            logic [7:0] e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_mis++; $display("FAIL wrap_data: got %02h want %02h", g, e); end
        end
        n_cmp++; if (bound_err !== 0) begin n_mis++; $display("FAIL wrap_count_bound: got %0d excursions want 0", bound_err); end
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL wrap_empty: got %0d want 0", count); end
        n_cmp++; if (overflow !== 1'b1) begin n_mis++; $display("FAIL wrap_overflow_sticky: got %b want 1", overflow); end
        n_cmp++; if (din_err !== 0) begin n_mis++; $display("FAIL din_stability: got %0d changes want 0", din_err); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_timeout_and_reset;
        bit ok;
        int c;
        int load0;
        int loads_after;
        model_mode = 1;
        wait_cycles(3);
        n_cmp++; if (te_timeout !== 1'b0) begin n_mis++; $display("FAIL teto_pre: got %b want 0", te_timeout); end
        drive_wr(1'b1, 8'h5A);
        exp_q.push_back(8'h5A);
        drive_wr(1'b1, 8'hC3);
        exp_q.push_back(8'hC3);
        drive_wr(1'b0, 8'h00);
        wait_got(1, 20, ok);
        load0 = last_load_cyc;
        c = 0;
        while (te_timeout !== 1'b1 && c < 40) begin
            @(posedge clk);
            c++;
        end
        @(negedge clk);
        n_cmp++; if (te_timeout !== 1'b1) begin n_mis++; $display("FAIL teto_set: got %b want 1", te_timeout); end
        n_cmp++; if (teto_cyc - load0 !== TE_TIMEOUT) begin n_mis++; $display("FAIL teto_delay: got %0d cycles want %0d", teto_cyc - load0, TE_TIMEOUT); end
        wait_got(2, 40, ok);
        n_cmp++; if (!ok) begin n_mis++; $display("FAIL teto_next_load: got %0d bytes want 2", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g = got_q.pop_front();
            logic [7:0] e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_mis++; $display("FAIL teto_data: got %02h want %02h", g, e); end
        end
        got_q.delete();
        exp_q.delete();

        // Reset while UART_top is busy with one byte and five more queued.
        wait_cycles(25);
        model_busy = 100;
        model_mode = 0;
        wait_cycles(2);
        for (int i = 0; i < 6; i++) begin
            drive_wr(1'b1, 8'h10 + 8'(i));
        end
        drive_wr(1'b0, 8'h00);
        wait_cycles(10);
        n_cmp++; if (count !== 5'd5) begin n_mis++; $display("FAIL mid_count: got %0d want 5", count); end
        n_cmp++; if (got_q.size() !== 1 || got_q[0] !== 8'h10) begin n_mis++; $display("FAIL mid_first_byte: got %0d bytes want 1 byte 10", got_q.size()); end
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        loads_after = n_loads;
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL mid_reset_count: got %0d want 0", count); end
        n_cmp++; if (te_timeout !== 1'b0) begin n_mis++; $display("FAIL mid_reset_teto: got %b want 0", te_timeout); end
        n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL mid_reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (uart_din !== 8'h00) begin n_mis++; $display("FAIL mid_reset_din: got %02h want 00", uart_din); end
        n_cmp++; if (cpu_te !== 1'b1) begin n_mis++; $display("FAIL mid_reset_cpu_te: got %b want 1", cpu_te); end
        wait_cycles(150);
        n_cmp++; if (n_loads !== loads_after) begin n_mis++; $display("FAIL mid_reset_no_load: got %0d loads want 0", n_loads - loads_after); end
        n_cmp++; if (count !== 5'd0) begin n_mis++; $display("FAIL mid_reset_stay_empty: got %0d want 0", count); end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        resetn  = 1'b0;
        cpu_wr  = 1'b0;
        cpu_din = 8'h00;
        test_reset;
        test_single_byte;
        test_burst;
        test_overflow;
        test_wrap;
        test_timeout_and_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
